half_adder: RTL and testbench

- Lane-wise half adder: bitwise sum = a XOR b and carry = a AND b across WIDTH independent lanes.
- Combinational outputs are valid in the same cycle the inputs settle.
- A registered copy, a valid flag and a saturating carry-event counter are provided for pipelined consumers and debug.
- Leaf arithmetic primitive used by ripple/carry-save adder builders and by the arithmetic lab datapaths.

---
 rtl/half_adder.sv | 66 ++++++
 tb/tb_half_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/half_adder.sv
// Lane-wise half adder with a combinational sum/carry, a registered copy qualified by
// in_valid, and a saturating count of accepted cycles that produced any carry.
module half_adder #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;
  logic             out_valid_d;
  logic             out_valid_q;
  logic [CNT_W-1:0] carry_count_d;
  logic [CNT_W-1:0] carry_count_q;

  // Lanes are independent: no carry ever crosses a lane boundary.
  always_comb begin
    sum   = a ^ b;
    carry = a & b;
  end

  always_comb begin
    sum_d         = sum_q;
    carry_d       = carry_q;
    out_valid_d   = 1'b0;
    carry_count_d = carry_count_q;
    if (in_valid) begin
      sum_d       = sum;
      carry_d     = carry;
      out_valid_d = 1'b1;
      // Saturate at all-ones rather than wrapping.
      if ((|carry) && (carry_count_q != {CNT_W{1'b1}})) begin
        carry_count_d = carry_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q         <= '0;
      carry_q       <= '0;
      out_valid_q   <= 1'b0;
      carry_count_q <= '0;
    end else begin
      sum_q         <= sum_d;
      carry_q       <= carry_d;
      out_valid_q   <= out_valid_d;
      carry_count_q <= carry_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign carry_count = carry_count_q;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: a 1-lane/16-bit-counter instance and a 4-lane/2-bit-counter instance.
module tb_half_adder;

  logic        clk;
  logic        rst_n;
  logic        a1, b1, v1;
  logic        s1, c1, sq1, cq1, ov1;
  logic [15:0] cnt1;
  logic [3:0]  a4, b4, s4, c4, sq4, cq4;
  logic        v4, ov4;
  logic [1:0]  cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  half_adder #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1),
    .out_valid(ov1), .carry_count(cnt1)
  );

  half_adder #(.WIDTH(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4),
    .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4),
    .out_valid(ov4), .carry_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic [3:0] carry;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each lane adds two one-bit numbers; low bit is sum, high bit is carry.
  function automatic logic [7:0] ref_add(input logic [3:0] x, input logic [3:0] y, input int w);
    logic [3:0] s;
    logic [3:0] c;
    int t;
    s = '0;
    c = '0;
    for (int i = 0; i < w; i++) begin
      t    = int'(x[i]) + int'(y[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
    return {c, s};
  endfunction

  // Model state for the random phase.
  logic [3:0] m_sq4, m_cq4;
  logic       m_sq1, m_cq1, m_ov1, m_ov4;
  int         m_cnt1, m_cnt4;

  initial begin
    vec_t vecs[7];
    logic [7:0] r1, r4;

    vecs[0] = '{a: 4'b0000, b: 4'b0000, sum: 4'b0000, carry: 4'b0000};
    vecs[1] = '{a: 4'b0000, b: 4'b0001, sum: 4'b0001, carry: 4'b0000};
    vecs[2] = '{a: 4'b0001, b: 4'b0000, sum: 4'b0001, carry: 4'b0000};
    vecs[3] = '{a: 4'b0001, b: 4'b0001, sum: 4'b0000, carry: 4'b0001};
    vecs[4] = '{a: 4'b1100, b: 4'b1010, sum: 4'b0110, carry: 4'b1000};
    vecs[5] = '{a: 4'b1111, b: 4'b0101, sum: 4'b1010, carry: 4'b0101};
    vecs[6] = '{a: 4'b1111, b: 4'b1111, sum: 4'b0000, carry: 4'b1111};

    // Reset held for two edges with a valid carry-producing input.
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    a4 = 4'b1111; b4 = 4'b1111; v4 = 1'b1;
    tick();
    tick();
    check("rst_sum_q1", 32'(sq1), 32'd0);
    check("rst_carry_q1", 32'(cq1), 32'd0);
    check("rst_out_valid1", 32'(ov1), 32'd0);
    check("rst_count1", 32'(cnt1), 32'd0);
    check("rst_count4", 32'(cnt4), 32'd0);
    check("rst_comb_sum1", 32'(s1), 32'd0);
    check("rst_comb_carry1", 32'(c1), 32'd1);

    // Combinational truth table, inputs held 10 ns each while reset is low.
    v1 = 1'b0;
    v4 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a4 = vecs[i].a;
      b4 = vecs[i].b;
      a1 = vecs[i].a[0];
      b1 = vecs[i].b[0];
      #10;
      check($sformatf("comb_sum4[%0d]", i), 32'(s4), 32'(vecs[i].sum));
      check($sformatf("comb_carry4[%0d]", i), 32'(c4), 32'(vecs[i].carry));
      check($sformatf("comb_sum1[%0d]", i), 32'(s1), 32'(vecs[i].sum[0]));
      check($sformatf("comb_carry1[%0d]", i), 32'(c1), 32'(vecs[i].carry[0]));
    end

    // One accepted 1+1 on the single lane, then an idle cycle.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
    tick();
    check("acc_sum_q1", 32'(sq1), 32'd0);
    check("acc_carry_q1", 32'(cq1), 32'd1);
    check("acc_out_valid1", 32'(ov1), 32'd1);
    check("acc_count1", 32'(cnt1), 32'd1);
    check("acc_sum_q4", 32'(sq4), 32'b0110);
    check("acc_carry_q4", 32'(cq4), 32'b1000);
    check("acc_count4", 32'(cnt4), 32'd1);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    v4 = 1'b0; a4 = 4'b0000; b4 = 4'b1111;
    tick();
    check("idle_out_valid1", 32'(ov1), 32'd0);
    check("idle_sum_q1", 32'(sq1), 32'd0);
    check("idle_carry_q1", 32'(cq1), 32'd1);
    check("idle_count1", 32'(cnt1), 32'd1);
    check("idle_sum_q4", 32'(sq4), 32'b0110);
    check("idle_carry_q4", 32'(cq4), 32'b1000);

    // Saturation of the 2-bit counter.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a4 = 4'b0001; b4 = 4'b0001; v4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("sat_count4[%0d]", k), 32'(cnt4), 32'((k + 1 > 3) ? 3 : k + 1));
    end

    // Mid-stream reset after two counts, then counting resumes from zero.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mid_count4_pre", 32'(cnt4), 32'd2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_sum_q4", 32'(sq4), 32'd0);
    check("mid_rst_carry_q4", 32'(cq4), 32'd0);
    check("mid_rst_out_valid4", 32'(ov4), 32'd0);
    check("mid_rst_count4", 32'(cnt4), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_resume_count4", 32'(cnt4), 32'd1);
    check("mid_resume_carry_q4", 32'(cq4), 32'b0001);
    check("mid_resume_out_valid4", 32'(ov4), 32'd1);

    // Random phase against the reference model.
    rst_n = 1'b0;
    tick();
    m_sq1 = 1'b0; m_cq1 = 1'b0; m_ov1 = 1'b0; m_cnt1 = 0;
    m_sq4 = '0;   m_cq4 = '0;   m_ov4 = 1'b0; m_cnt4 = 0;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(15) != 0);
      v1 = ($urandom_range(3) != 0);
      v4 = ($urandom_range(3) != 0);
      a1 = $urandom_range(1);
      b1 = $urandom_range(1);
      a4 = 4'($urandom_range(15));
      b4 = 4'($urandom_range(15));
      #1;
      r1 = ref_add({3'b000, a1}, {3'b000, b1}, 1);
      r4 = ref_add(a4, b4, 4);
      check("rnd_sum1", 32'(s1), 32'(r1[0]));
      check("rnd_carry1", 32'(c1), 32'(r1[4]));
      check("rnd_sum4", 32'(s4), 32'(r4[3:0]));
      check("rnd_carry4", 32'(c4), 32'(r4[7:4]));
      if (!rst_n) begin
        m_sq1 = 1'b0; m_cq1 = 1'b0; m_ov1 = 1'b0; m_cnt1 = 0;
        m_sq4 = '0;   m_cq4 = '0;   m_ov4 = 1'b0; m_cnt4 = 0;
      end else begin
        m_ov1 = v1;
        if (v1) begin
          m_sq1 = r1[0];
          m_cq1 = r1[4];
          if (r1[4]) m_cnt1 = (m_cnt1 == 65535) ? 65535 : m_cnt1 + 1;
        end
        m_ov4 = v4;
        if (v4) begin
          m_sq4 = r4[3:0];
          m_cq4 = r4[7:4];
          if (r4[7:4] != 4'b0000) m_cnt4 = (m_cnt4 == 3) ? 3 : m_cnt4 + 1;
        end
      end
      tick();
      check("rnd_sum_q1", 32'(sq1), 32'(m_sq1));
      check("rnd_carry_q1", 32'(cq1), 32'(m_cq1));
      check("rnd_out_valid1", 32'(ov1), 32'(m_ov1));
      check("rnd_count1", 32'(cnt1), 32'(m_cnt1));
      check("rnd_sum_q4", 32'(sq4), 32'(m_sq4));
      check("rnd_carry_q4", 32'(cq4), 32'(m_cq4));
      check("rnd_out_valid4", 32'(ov4), 32'(m_ov4));
      check("rnd_count4", 32'(cnt4), 32'(m_cnt4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
